// File: rtl/self_attention_head_gather_pkg.sv
// Shared transformer helpers: tiling-depth and per-head block-count math used
// by both the head scatter and head gather stages.
package self_attention_head_gather_pkg;

  function automatic int unsigned calc_depth(int unsigned size, int unsigned par);
    return size / par;
  endfunction

  function automatic int unsigned calc_blocks_per_head(int unsigned size0, int unsigned par0,
                                                       int unsigned heads);
    return (size0 / par0) / heads;
  endfunction

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/self_attention_head_gather.sv
// Gathers per-head block streams back into one activation stream in channel
// order, with a one-entry registered output and a per-tensor last flag.
module self_attention_head_gather
  import self_attention_head_gather_pkg::*;
#(
  parameter int unsigned NUM_HEADS                 = 12,
  parameter int unsigned IN_DATA_TENSOR_SIZE_DIM_0 = 64,
  parameter int unsigned IN_DATA_TENSOR_SIZE_DIM_1 = 32,
  parameter int unsigned IN_DATA_PARALLELISM_DIM_0 = 4,
  parameter int unsigned IN_DATA_PARALLELISM_DIM_1 = 4,
  parameter int unsigned DATA_WIDTH                = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HEADS*IN_DATA_PARALLELISM_DIM_0*IN_DATA_PARALLELISM_DIM_1*DATA_WIDTH-1:0]
                                in_data,
  input  logic [NUM_HEADS-1:0]  in_valid,
  output logic [NUM_HEADS-1:0]  in_ready,
  output logic [IN_DATA_PARALLELISM_DIM_0*IN_DATA_PARALLELISM_DIM_1*DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int unsigned BLOCK_ELEMS     = IN_DATA_PARALLELISM_DIM_0 * IN_DATA_PARALLELISM_DIM_1;
  localparam int unsigned BLOCK_BITS      = BLOCK_ELEMS * DATA_WIDTH;
  localparam int unsigned DEPTH_DIM_0     = calc_depth(IN_DATA_TENSOR_SIZE_DIM_0,
                                                       IN_DATA_PARALLELISM_DIM_0);
  localparam int unsigned DEPTH_DIM_1     = calc_depth(IN_DATA_TENSOR_SIZE_DIM_1,
                                                       IN_DATA_PARALLELISM_DIM_1);
  localparam int unsigned BLOCKS_PER_HEAD = calc_blocks_per_head(IN_DATA_TENSOR_SIZE_DIM_0,
                                                                 IN_DATA_PARALLELISM_DIM_0,
                                                                 NUM_HEADS);
  localparam int unsigned BCW = cnt_width(BLOCKS_PER_HEAD);
  localparam int unsigned HCW = cnt_width(NUM_HEADS);
  localparam int unsigned RCW = cnt_width(DEPTH_DIM_1);

  localparam bit CFG_OK = (IN_DATA_TENSOR_SIZE_DIM_0 % IN_DATA_PARALLELISM_DIM_0 == 0) &&
                          (IN_DATA_TENSOR_SIZE_DIM_1 % IN_DATA_PARALLELISM_DIM_1 == 0) &&
                          (BLOCKS_PER_HEAD * NUM_HEADS == DEPTH_DIM_0);

  cfg_ok_a: assert property (@(posedge clk) CFG_OK);

  logic [BCW-1:0]        block_cnt_q, block_cnt_d;
  logic [HCW-1:0]        head_cnt_q, head_cnt_d;
  logic [RCW-1:0]        row_cnt_q, row_cnt_d;
  logic [BLOCK_BITS-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic                  can_load;
  logic                  sel_valid;
  logic                  accept;
  logic [BLOCK_BITS-1:0] sel_data;
  logic                  block_max, head_max, row_max;

  // Grant depends only on the counter and output-register state, never on in_valid.
  always_comb begin
    can_load  = !out_valid_q || out_ready;
    sel_valid = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int h = 0; h < NUM_HEADS; h++) begin
      if (head_cnt_q == HCW'(h)) begin
        sel_valid   = in_valid[h];
        sel_data    = in_data[h*BLOCK_BITS +: BLOCK_BITS];
        in_ready[h] = can_load && rst;
      end
    end
    accept = sel_valid && can_load;
  end

  always_comb begin
    block_max   = (block_cnt_q == BCW'(BLOCKS_PER_HEAD - 1));
    head_max    = (head_cnt_q == HCW'(NUM_HEADS - 1));
    row_max     = (row_cnt_q == RCW'(DEPTH_DIM_1 - 1));
    block_cnt_d = block_cnt_q;
    head_cnt_d  = head_cnt_q;
    row_cnt_d   = row_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_data_d  = sel_data;
      out_valid_d = 1'b1;
      out_last_d  = block_max && head_max && row_max;
      if (block_max) begin
        block_cnt_d = '0;
        if (head_max) begin
          head_cnt_d = '0;
          row_cnt_d  = row_max ? '0 : row_cnt_q + RCW'(1);
        end else begin
          head_cnt_d = head_cnt_q + HCW'(1);
        end
      end else begin
        block_cnt_d = block_cnt_q + BCW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_cnt_q <= '0;
      head_cnt_q  <= '0;
      row_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      block_cnt_q <= block_cnt_d;
      head_cnt_q  <= head_cnt_d;
      row_cnt_q   <= row_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_self_attention_head_gather.sv
// Directed table-driven bench for the head gather stage in a 2-head, 8-beat configuration.
module tb_self_attention_head_gather;

  localparam int unsigned NH = 2;
  localparam int unsigned BB = 128;

  logic              clk;
  logic              rst;
  logic [NH*BB-1:0]  in_data;
  logic [NH-1:0]     in_valid;
  logic [NH-1:0]     in_ready;
  logic [BB-1:0]     out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  self_attention_head_gather #(
    .NUM_HEADS                 (2),
    .IN_DATA_TENSOR_SIZE_DIM_0 (16),
    .IN_DATA_TENSOR_SIZE_DIM_1 (8),
    .IN_DATA_PARALLELISM_DIM_0 (4),
    .IN_DATA_PARALLELISM_DIM_1 (4),
    .DATA_WIDTH                (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] vld;
    logic       ordy;
    logic [1:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_byte;
    logic       exp_last;
  } vec_t;

  vec_t tbl[$];
  int   ptr[NH];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(logic [1:0] vld, logic ordy, logic [1:0] rdy, logic ov,
                              logic [7:0] b, logic last);
    vec_t v;
    v.vld = vld; v.ordy = ordy; v.exp_rdy = rdy;
    v.exp_ov = ov; v.exp_byte = b; v.exp_last = last;
    tbl.push_back(v);
  endfunction

  // Each head's source tags its blocks with {head+1, sequence number}.
  task automatic drive_data();
    logic [7:0] b;
    for (int h = 0; h < NH; h++) begin
      b = {4'(h + 1), 4'(ptr[h])};
      in_data[h*BB +: BB] = {16{b}};
    end
  endtask

  task automatic chk(string name, logic [BB-1:0] got, logic [BB-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(int idx);
    vec_t       v;
    logic [1:0] rdy;
    logic [7:0] eb;
    v         = tbl[idx];
    in_valid  = v.vld;
    out_ready = v.ordy;
    drive_data();
    #1;
    rdy = in_ready;
    chk($sformatf("in_ready[%0d]", idx), BB'(rdy), BB'(v.exp_rdy));
    @(posedge clk);
    for (int h = 0; h < NH; h++) if (v.vld[h] && rdy[h]) ptr[h]++;
    #1;
    eb = v.exp_byte;
    chk($sformatf("out_valid[%0d]", idx), BB'(out_valid), BB'(v.exp_ov));
    chk($sformatf("out_data[%0d]", idx), out_data, {16{eb}});
    chk($sformatf("out_last[%0d]", idx), BB'(out_last), BB'(v.exp_last));
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_in_ready"}, BB'(in_ready), '0);
    chk({tag, "_out_valid"}, BB'(out_valid), '0);
    chk({tag, "_out_last"}, BB'(out_last), '0);
    chk({tag, "_out_data"}, out_data, '0);
  endtask

  initial begin
    // Rows 0..16: two back-to-back tensors, then an idle cycle.
    add(2'b11, 1, 2'b01, 1, 8'h10, 0);
    add(2'b11, 1, 2'b01, 1, 8'h11, 0);
    add(2'b11, 1, 2'b10, 1, 8'h20, 0);
    add(2'b11, 1, 2'b10, 1, 8'h21, 0);
    add(2'b11, 1, 2'b01, 1, 8'h12, 0);
    add(2'b11, 1, 2'b01, 1, 8'h13, 0);
    add(2'b11, 1, 2'b10, 1, 8'h22, 0);
    add(2'b11, 1, 2'b10, 1, 8'h23, 1);
    add(2'b11, 1, 2'b01, 1, 8'h14, 0);
    add(2'b11, 1, 2'b01, 1, 8'h15, 0);
    add(2'b11, 1, 2'b10, 1, 8'h24, 0);
    add(2'b11, 1, 2'b10, 1, 8'h25, 0);
    add(2'b11, 1, 2'b01, 1, 8'h16, 0);
    add(2'b11, 1, 2'b01, 1, 8'h17, 0);
    add(2'b11, 1, 2'b10, 1, 8'h26, 0);
    add(2'b11, 1, 2'b10, 1, 8'h27, 1);
    add(2'b00, 1, 2'b01, 0, 8'h27, 1);
    // Rows 17..21: head 0 stalls after B0 while head 1 stays valid.
    add(2'b11, 1, 2'b01, 1, 8'h18, 0);
    add(2'b10, 1, 2'b01, 0, 8'h18, 0);
    add(2'b10, 1, 2'b01, 0, 8'h18, 0);
    add(2'b11, 1, 2'b01, 1, 8'h19, 0);
    add(2'b11, 1, 2'b10, 1, 8'h28, 0);
    // Rows 22..26: three cycles of backpressure, then release.
    add(2'b11, 0, 2'b00, 1, 8'h28, 0);
    add(2'b11, 0, 2'b00, 1, 8'h28, 0);
    add(2'b11, 0, 2'b00, 1, 8'h28, 0);
    add(2'b11, 1, 2'b10, 1, 8'h29, 0);
    add(2'b11, 1, 2'b01, 1, 8'h1a, 0);
    // Rows 27..34: full tensor after a mid-stream reset.
    add(2'b11, 1, 2'b01, 1, 8'h10, 0);
    add(2'b11, 1, 2'b01, 1, 8'h11, 0);
    add(2'b11, 1, 2'b10, 1, 8'h20, 0);
    add(2'b11, 1, 2'b10, 1, 8'h21, 0);
    add(2'b11, 1, 2'b01, 1, 8'h12, 0);
    add(2'b11, 1, 2'b01, 1, 8'h13, 0);
    add(2'b11, 1, 2'b10, 1, 8'h22, 0);
    add(2'b11, 1, 2'b10, 1, 8'h23, 1);

    for (int h = 0; h < NH; h++) ptr[h] = 0;
    rst       = 1'b0;
    in_valid  = 2'b11;
    out_ready = 1'b1;
    in_data   = '0;
    drive_data();

    // Reset held for two clock edges with all heads valid.
    #1;
    chk_reset_outputs("por0");
    @(negedge clk);
    chk_reset_outputs("por1");
    @(negedge clk);
    chk_reset_outputs("por2");
    rst = 1'b1;
    #1;
    chk("post_reset_in_ready", BB'(in_ready), BB'(2'b01));

    for (int i = 0; i <= 26; i++) apply(i);

    // Asynchronous reset between clock edges, mid-tensor.
    rst = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    chk_reset_outputs("async_hold");
    rst = 1'b1;
    for (int h = 0; h < NH; h++) ptr[h] = 0;

    for (int i = 27; i <= 34; i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
